// File: rtl/mem_slave_pkg.sv
// Shared types and constants for the memory slave: FSM encoding, wait-counter width, default geometry.
package mem_slave_pkg;

  localparam int CNT_W     = 4;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_slave_array.sv
// Storage for the memory slave: one lane-masked write port, one combinational read port,
// whole array cleared asynchronously while rst is low.
module mem_slave_array
  import mem_slave_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int LANES      = (WIDTH + 7) / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [LANES-1:0]      lane_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rd_word
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      // Bit b belongs to byte lane b/8.
      for (int b = 0; b < WIDTH; b++) begin
        if (lane_en[b/8]) mem[addr][b] <= wdata[b];
      end
    end
  end

  assign rd_word = mem[addr];

endmodule

// File: rtl/mem_slave_ctrl.sv
// Memory slave controller: valid/ready request capture, wait-state FSM, range check, response registers.
// Define MEM_STRB_EN to add the strb port and per-byte-lane write enables.
//
// state | meaning
// IDLE  | waiting for valid; accepts and captures a request
// WAIT  | counting down wait states using captured request fields
// RESP  | ready pulse cycle; valid ignored
module mem_slave_ctrl
  import mem_slave_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int ADDR_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic                  wr_rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
`ifdef MEM_STRB_EN
  input  logic [WIDTH/8-1:0]    strb,
`endif
  output logic                  ready,
  output logic [WIDTH-1:0]      rdata,
  output logic                  err
);

`ifdef MEM_STRB_EN
  localparam int LANES = WIDTH / 8;
`else
  localparam int LANES = (WIDTH + 7) / 8;
`endif

  localparam bit                  NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam logic [ADDR_WIDTH:0] DEPTH_V  = (ADDR_WIDTH + 1)'(DEPTH);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  logic                  cap_wr;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [WIDTH-1:0]      cap_wdata;
  logic [LANES-1:0]      cap_lanes;
  logic [LANES-1:0]      live_lanes;

  logic                  acc_wr;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [WIDTH-1:0]      acc_wdata;
  logic [LANES-1:0]      acc_lanes;
  logic                  do_access;
  logic                  in_range;
  logic [WIDTH-1:0]      rd_word;

`ifdef MEM_STRB_EN
  assign live_lanes = strb;
`else
  assign live_lanes = '1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (valid) begin
          if (NO_WAIT) begin
            state_nx = RESP;
          end else begin
            state_nx = WAIT;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) state_nx = RESP;
        else           cnt_nx   = cnt - 1'b1;
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_wr    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_lanes <= '0;
    end else if (state == IDLE && valid) begin
      cap_wr    <= wr_rd;
      cap_addr  <= addr;
      cap_wdata <= wdata;
      cap_lanes <= live_lanes;
    end
  end

  // With no wait states the access happens on the accepting edge, so it must use the live bus.
  always_comb begin
    acc_wr    = cap_wr;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_lanes = cap_lanes;
    if (state == IDLE) begin
      acc_wr    = wr_rd;
      acc_addr  = addr;
      acc_wdata = wdata;
      acc_lanes = live_lanes;
    end
  end

  assign do_access = (state == IDLE && valid && NO_WAIT) || (state == WAIT && cnt == '0);
  assign in_range  = ({1'b0, acc_addr} < DEPTH_V);

  mem_slave_array #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .LANES      (LANES)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (do_access && acc_wr && in_range),
    .lane_en (acc_lanes),
    .addr    (acc_addr),
    .wdata   (acc_wdata),
    .rd_word (rd_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      ready <= do_access;
      err   <= do_access && !in_range;
      if (do_access && !acc_wr) rdata <= in_range ? rd_word : '0;
    end
  end

endmodule

// File: tb/tb_mem_slave_ctrl.sv
// Directed bench for mem_slave_ctrl: three instances (0, 3 and 4 wait states, DEPTH=20) sharing bus
// fields and reset, each with its own valid. Covers strobes when MEM_STRB_EN is defined.
module tb_mem_slave_ctrl;

  logic        clk;
  logic        rst;
  logic        valid [3];
  logic        wr_rd;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  strb;
  logic        ready_a [3];
  logic [15:0] rdata_a [3];
  logic        err_a [3];

  int total = 0;
  int bad   = 0;

  logic [15:0] rd;
  logic        e;

  mem_slave_ctrl #(.WIDTH(16), .DEPTH(20), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst), .valid(valid[0]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
`ifdef MEM_STRB_EN
    .strb(strb),
`endif
    .ready(ready_a[0]), .rdata(rdata_a[0]), .err(err_a[0]));

  mem_slave_ctrl #(.WIDTH(16), .DEPTH(20), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst), .valid(valid[1]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
`ifdef MEM_STRB_EN
    .strb(strb),
`endif
    .ready(ready_a[1]), .rdata(rdata_a[1]), .err(err_a[1]));

  mem_slave_ctrl #(.WIDTH(16), .DEPTH(20), .WAIT_STATES(4)) u_w4 (
    .clk(clk), .rst(rst), .valid(valid[2]), .wr_rd(wr_rd), .addr(addr), .wdata(wdata),
`ifdef MEM_STRB_EN
    .strb(strb),
`endif
    .ready(ready_a[2]), .rdata(rdata_a[2]), .err(err_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance k; checks response latency and that ready/err last one cycle.
  task automatic req(input int k, input logic w, input logic [4:0] a, input logic [15:0] d,
                     input logic [1:0] s, input int exp_lat, input bit chg, input logic [4:0] a2,
                     input string tag, output logic [15:0] rd_o, output logic e_o);
    int lat;
    @(negedge clk);
    wr_rd = w; addr = a; wdata = d; strb = s; valid[k] = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (chg && lat == 1) addr = a2;
    end while (!ready_a[k] && lat < 20);
    chk({tag, "_lat"}, lat, exp_lat);
    rd_o = rdata_a[k];
    e_o  = err_a[k];
    valid[k] = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_fall"}, {31'd0, ready_a[k]}, 32'd0);
    chk({tag, "_err_fall"}, {31'd0, err_a[k]}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    wr_rd = 1'b0; addr = '0; wdata = '0; strb = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'd0, ready_a[0]}, 32'd0);
    chk("reset_rdata", {16'd0, rdata_a[0]}, 32'd0);
    chk("reset_err",   {31'd0, err_a[0]}, 32'd0);
    rst = 1'b1;

    req(0, 1'b0, 5'd5, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd5_idle", rd, e);
    chk("rd5_data", {16'd0, rd}, 32'h0000);
    chk("rd5_err",  {31'd0, e}, 32'd0);

    req(0, 1'b1, 5'd7, 16'hA5C3, 2'b11, 1, 1'b0, 5'd0, "wr7", rd, e);
    chk("wr7_err", {31'd0, e}, 32'd0);
    req(0, 1'b0, 5'd7, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd7", rd, e);
    chk("rd7_data", {16'd0, rd}, 32'hA5C3);
    req(0, 1'b1, 5'd3, 16'h1111, 2'b11, 1, 1'b0, 5'd0, "wr3", rd, e);
    chk("rdata_hold", {16'd0, rdata_a[0]}, 32'hA5C3);

    // Three wait states: addr switched to 7 during WAIT must not matter.
    req(1, 1'b1, 5'd9, 16'h0BEE, 2'b11, 4, 1'b0, 5'd0, "w3_wr9", rd, e);
    req(1, 1'b0, 5'd9, 16'h0, 2'b11, 4, 1'b1, 5'd7, "w3_rd9", rd, e);
    chk("w3_rd9_data", {16'd0, rd}, 32'h0BEE);

    req(0, 1'b1, 5'd19, 16'h1919, 2'b11, 1, 1'b0, 5'd0, "wr19", rd, e);
    req(0, 1'b1, 5'd25, 16'hFFFF, 2'b11, 1, 1'b0, 5'd0, "wr25", rd, e);
    chk("wr25_err", {31'd0, e}, 32'd1);
    req(0, 1'b0, 5'd25, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd25", rd, e);
    chk("rd25_data", {16'd0, rd}, 32'h0000);
    chk("rd25_err",  {31'd0, e}, 32'd1);
    req(0, 1'b0, 5'd19, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd19", rd, e);
    chk("rd19_data", {16'd0, rd}, 32'h1919);
    chk("rd19_err",  {31'd0, e}, 32'd0);

    req(0, 1'b1, 5'd2, 16'h1234, 2'b11, 1, 1'b0, 5'd0, "wr2a", rd, e);
    req(0, 1'b1, 5'd2, 16'hABCD, 2'b10, 1, 1'b0, 5'd0, "wr2b", rd, e);
    req(0, 1'b0, 5'd2, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd2", rd, e);
`ifdef MEM_STRB_EN
    chk("rd2_strb", {16'd0, rd}, 32'hAB34);
    req(0, 1'b1, 5'd2, 16'h0000, 2'b00, 1, 1'b0, 5'd0, "wr2_nostrb", rd, e);
    chk("wr2_nostrb_err", {31'd0, e}, 32'd0);
    req(0, 1'b0, 5'd2, 16'h0, 2'b11, 1, 1'b0, 5'd0, "rd2c", rd, e);
    chk("rd2c_data", {16'd0, rd}, 32'hAB34);
`else
    chk("rd2_full", {16'd0, rd}, 32'hABCD);
`endif

    // Reset during WAIT of a write on the four-wait-state instance.
    @(negedge clk);
    wr_rd = 1'b1; addr = 5'd1; wdata = 16'h5555; valid[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_no_ready", {31'd0, ready_a[2]}, 32'd0);
    rst = 1'b0;
    valid[2] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 2) rst = 1'b1;
      chk("mid_rst_ready", {31'd0, ready_a[2]}, 32'd0);
    end
    req(2, 1'b0, 5'd1, 16'h0, 2'b11, 5, 1'b0, 5'd0, "w4_rd1", rd, e);
    chk("w4_rd1_data", {16'd0, rd}, 32'h0000);
    chk("w4_rd1_err",  {31'd0, e}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
